// File: rtl/load_txn_gen_pkg.sv
// Shared types and constants for the vector-load request generator.
package vlsu_pkg;

  localparam int unsigned PAGE_BYTES     = 4096;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  // Fixed maxima for the txn record; the top slices these down to its parameterised widths.
  localparam int unsigned LDGEN_OFF_W   = 12;
  localparam int unsigned LDGEN_BYTES_W = 32;

  typedef enum logic [1:0] {
    LDGEN_IDLE,
    LDGEN_ISSUE,
    LDGEN_DONE
  } ldgen_state_e;

  typedef struct packed {
    logic [LDGEN_OFF_W-1:0]   offset;
    logic [LDGEN_BYTES_W-1:0] bytes;
    logic                     last;
  } ldgen_txn_t;

endpackage

// File: rtl/load_txn_gen_if.sv
// Request, AXI AR and transaction-control signals of load_txn_gen.
interface load_txn_gen_if #(
  parameter int unsigned AxiDataWidth  = 256,
  parameter int unsigned AxiAddrWidth  = 64,
  parameter int unsigned AxiIdWidth    = 4,
  parameter int unsigned ReqBytesWidth = 16
);
  localparam int unsigned BusBSize = $clog2(AxiDataWidth / 8);

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [AxiAddrWidth-1:0]  req_addr_i;
  logic [ReqBytesWidth-1:0] req_bytes_i;
  logic [AxiIdWidth-1:0]    req_id_i;

  logic                     ar_valid_o;
  logic                     ar_ready_i;
  logic [AxiAddrWidth-1:0]  ar_addr_o;
  logic [7:0]               ar_len_o;
  logic [2:0]               ar_size_o;
  logic [1:0]               ar_burst_o;
  logic [AxiIdWidth-1:0]    ar_id_o;

  logic                     txn_valid_o;
  logic                     txn_ready_i;
  logic [BusBSize-1:0]      txn_offset_o;
  logic [ReqBytesWidth-1:0] txn_bytes_o;
  logic                     txn_last_o;

  logic                     r_last_hs_i;
  logic                     req_done_o;

  modport master (
    input  req_valid_i, req_addr_i, req_bytes_i, req_id_i,
    input  ar_ready_i, txn_ready_i, r_last_hs_i,
    output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
    output txn_valid_o, txn_offset_o, txn_bytes_o, txn_last_o, req_done_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_bytes_i, req_id_i,
    output ar_ready_i, txn_ready_i, r_last_hs_i,
    input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
    input  txn_valid_o, txn_offset_o, txn_bytes_o, txn_last_o, req_done_o
  );

endinterface

// File: rtl/load_txn_gen_burst_calc.sv
// Combinational burst sizing: chunk limited by remaining bytes, 4 KiB page and MaxBurstLen.
module ldgen_burst_calc
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth  = 256,
  parameter int unsigned ReqBytesWidth = 16,
  parameter int unsigned MaxBurstLen   = 256
) (
  input  logic [11:0]              addr_lo,
  input  logic [ReqBytesWidth-1:0] rem,
  output logic [7:0]               ar_len,
  output ldgen_txn_t               txn
);

  localparam int unsigned BusBytes = AxiDataWidth / 8;
  localparam int unsigned BusBSize = $clog2(BusBytes);
  localparam int unsigned CalcW    = (ReqBytesWidth > 24 ? ReqBytesWidth : 24) + 1;
  localparam logic [CalcW-1:0] MaxBurstBytes = CalcW'(MaxBurstLen * BusBytes);

  logic [BusBSize-1:0] off;
  logic [12:0]         to4k;
  logic [CalcW-1:0]    off_w, rem_w, to4k_w, maxb_w, chunk_w, end_w, beats_w;

  always_comb begin
    off     = addr_lo[BusBSize-1:0];
    to4k    = 13'(PAGE_BYTES) - {1'b0, addr_lo};
    off_w   = CalcW'(off);
    rem_w   = CalcW'(rem);
    to4k_w  = CalcW'(to4k);
    maxb_w  = MaxBurstBytes - off_w;

    chunk_w = rem_w;
    if (to4k_w < chunk_w) chunk_w = to4k_w;
    if (maxb_w < chunk_w) chunk_w = maxb_w;

    end_w   = off_w + chunk_w + CalcW'(BusBytes - 1);
    beats_w = end_w >> BusBSize;
    ar_len  = 8'(beats_w - CalcW'(1));

    txn        = '0;
    txn.offset = LDGEN_OFF_W'(off);
    txn.bytes  = LDGEN_BYTES_W'(chunk_w);
    txn.last   = (chunk_w == rem_w);
  end

endmodule

// File: rtl/load_txn_gen.sv
// Splits a vector-load request into 4 KiB-safe AXI INCR bursts with a forked AR/txn handshake.
// Optional burst-credit limit on AR issue: define RIVA_LDGEN_OUTSTANDING_LIMIT_EN.
module load_txn_gen
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth   = 256,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned ReqBytesWidth  = 16,
  parameter int unsigned MaxBurstLen    = 256,
  parameter int unsigned MaxOutstanding = 8
) (
  input logic            clk_i,
  input logic            rst_ni,
  load_txn_gen_if.master bus
);

  localparam int unsigned BusBytes = AxiDataWidth / 8;
  localparam int unsigned BusBSize = $clog2(BusBytes);

  if (MaxBurstLen < 1 || MaxBurstLen > 256 || MaxOutstanding < 1 ||
      BusBSize > LDGEN_OFF_W || ReqBytesWidth >= LDGEN_BYTES_W) begin : g_bad_cfg
    $error("load_txn_gen: unsupported parameter set");
  end

  ldgen_state_e             state_q, state_d;
  logic [AxiAddrWidth-1:0]  addr_q, addr_d;
  logic [ReqBytesWidth-1:0] rem_q, rem_d;
  logic [AxiIdWidth-1:0]    id_q, id_d;
  logic                     ar_done_q, ar_done_d;
  logic                     txn_done_q, txn_done_d;

  logic                     req_ready, req_done;
  logic                     ar_valid, txn_valid, ar_hs, txn_hs;
  logic                     credit_full;
  logic                     issuing;

  logic [7:0]               calc_len;
  ldgen_txn_t               calc_txn;
  logic [ReqBytesWidth-1:0] chunk;
  logic                     unused_calc;

  ldgen_burst_calc #(
    .AxiDataWidth (AxiDataWidth),
    .ReqBytesWidth(ReqBytesWidth),
    .MaxBurstLen  (MaxBurstLen)
  ) u_calc (
    .addr_lo(addr_q[11:0]),
    .rem    (rem_q),
    .ar_len (calc_len),
    .txn    (calc_txn)
  );

  assign chunk       = calc_txn.bytes[ReqBytesWidth-1:0];
  assign unused_calc = ^calc_txn;

`ifdef RIVA_LDGEN_OUTSTANDING_LIMIT_EN
  localparam int unsigned CreditW = $clog2(MaxOutstanding + 1);
  logic [CreditW-1:0] credit_q;
  logic               credit_dec;

  // A release pulse with no credit outstanding is spurious and ignored.
  assign credit_dec = bus.r_last_hs_i && (credit_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
    end else if (ar_hs && !credit_dec) begin
      credit_q <= credit_q + CreditW'(1);
    end else if (!ar_hs && credit_dec) begin
      credit_q <= credit_q - CreditW'(1);
    end
  end

  assign credit_full = (credit_q == CreditW'(MaxOutstanding));
`else
  logic unused_r_last;
  assign unused_r_last = bus.r_last_hs_i;
  assign credit_full   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LDGEN_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      ar_done_q  <= 1'b0;
      txn_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      ar_done_q  <= ar_done_d;
      txn_done_q <= txn_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    id_d       = id_q;
    ar_done_d  = ar_done_q;
    txn_done_d = txn_done_q;
    req_ready  = 1'b0;
    req_done   = 1'b0;
    ar_valid   = 1'b0;
    txn_valid  = 1'b0;
    ar_hs      = 1'b0;
    txn_hs     = 1'b0;

    unique case (state_q)
      LDGEN_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) begin
          addr_d     = bus.req_addr_i;
          rem_d      = bus.req_bytes_i;
          id_d       = bus.req_id_i;
          ar_done_d  = 1'b0;
          txn_done_d = 1'b0;
          state_d    = (bus.req_bytes_i == '0) ? LDGEN_DONE : LDGEN_ISSUE;
        end
      end
      LDGEN_ISSUE: begin
        ar_valid  = !ar_done_q && !credit_full;
        txn_valid = !txn_done_q;
        ar_hs     = ar_valid && bus.ar_ready_i;
        txn_hs    = txn_valid && bus.txn_ready_i;
        // Burst retires once both branches have handshaken, in this cycle or earlier.
        if ((ar_done_q || ar_hs) && (txn_done_q || txn_hs)) begin
          addr_d     = addr_q + AxiAddrWidth'(chunk);
          rem_d      = rem_q - chunk;
          ar_done_d  = 1'b0;
          txn_done_d = 1'b0;
          if (calc_txn.last) state_d = LDGEN_DONE;
        end else begin
          ar_done_d  = ar_done_q || ar_hs;
          txn_done_d = txn_done_q || txn_hs;
        end
      end
      LDGEN_DONE: begin
        req_done = 1'b1;
        state_d  = LDGEN_IDLE;
      end
      default: state_d = LDGEN_IDLE;
    endcase
  end

  assign issuing = (state_q == LDGEN_ISSUE);

  assign bus.req_ready_o  = req_ready;
  assign bus.req_done_o   = req_done;
  assign bus.ar_valid_o   = ar_valid;
  assign bus.ar_addr_o    = issuing ? {addr_q[AxiAddrWidth-1:BusBSize], {BusBSize{1'b0}}} : '0;
  assign bus.ar_len_o     = issuing ? calc_len : '0;
  assign bus.ar_size_o    = 3'(BusBSize);
  assign bus.ar_burst_o   = AXI_BURST_INCR;
  assign bus.ar_id_o      = issuing ? id_q : '0;
  assign bus.txn_valid_o  = txn_valid;
  assign bus.txn_offset_o = issuing ? calc_txn.offset[BusBSize-1:0] : '0;
  assign bus.txn_bytes_o  = issuing ? chunk : '0;
  assign bus.txn_last_o   = issuing && calc_txn.last;

  logic [AxiAddrWidth:0] req_end;
  assign req_end = {1'b0, bus.req_addr_i} + (AxiAddrWidth + 1)'(bus.req_bytes_i);

  // Requests running past the top of the address space are not supported.
  a_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.req_valid_i && req_ready) |-> (!req_end[AxiAddrWidth] || req_end[AxiAddrWidth-1:0] == '0));

endmodule
